// File: rtl/inv_factorial_pkg.sv
// Shared widths, state encoding and helpers for the inverse-factorial block.
// Optional abort input is enabled by defining INV_FACTORIAL_ABORT_EN.
package inv_factorial_pkg;

  localparam int IN_W  = 16;
  localparam int N_W   = 4;
  localparam int ACC_W = 20;
  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Zero-extend an operand to the accumulator width so compares are lossless.
  function automatic logic [ACC_W-1:0] widen_in(input logic [IN_W-1:0] v);
    return {{(ACC_W-IN_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/inv_factorial_fact_step.sv
// Combinational step: p = acc*(k+1) at full accumulator width, le = (p <= v).
module fact_step
  import inv_factorial_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [N_W-1:0]   k,
  input  logic [IN_W-1:0]  v,
  output logic [ACC_W-1:0] p,
  output logic             le
);

  logic [ACC_W-1:0] mult;

  assign mult = ACC_W'(k) + ACC_W'(1);
  assign p    = acc * mult;
  assign le   = (p <= widen_in(v));

endmodule

// File: rtl/inv_factorial.sv
// Finds the largest n with n! <= in, one multiply step per cycle.
// Define INV_FACTORIAL_ABORT_EN to add the abort input.
//
// Handshake: start is sampled only in IDLE; busy is high exactly in CALC;
// done pulses for the single DONE cycle, from which out/exact are valid and
// then held until the next DONE.
module inv_factorial
  import inv_factorial_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] in,
`ifdef INV_FACTORIAL_ABORT_EN
  input  logic            abort,
`endif
  output logic [N_W-1:0]  out,
  output logic            exact,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state
);

  state_t           state, state_next;
  logic [IN_W-1:0]  v_q;
  logic [ACC_W-1:0] acc;
  logic [N_W-1:0]   k;

  logic [ACC_W-1:0] p;
  logic             le;

  logic load, adv, fin, zero_res;

  fact_step u_step (
    .acc (acc),
    .k   (k),
    .v   (v_q),
    .p   (p),
    .le  (le)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    adv        = 1'b0;
    fin        = 1'b0;
    zero_res   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (in == '0) begin
            zero_res   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
`ifdef INV_FACTORIAL_ABORT_EN
        if (abort) state_next = IDLE;
        else
`endif
        // The k bound is a backstop; 9! already exceeds any operand.
        if (le && (k < N_W'(MAX_N))) begin
          adv = 1'b1;
        end else begin
          fin        = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      acc   <= ACC_W'(1);
      k     <= N_W'(1);
      out   <= '0;
      exact <= 1'b0;
    end else begin
      if (load) begin
        v_q <= in;
        acc <= ACC_W'(1);
        k   <= N_W'(1);
      end
      if (adv) begin
        acc <= p;
        k   <= k + N_W'(1);
      end
      if (fin) begin
        out   <= k;
        exact <= (acc == widen_in(v_q));
      end
      if (zero_res) begin
        out   <= '0;
        exact <= 1'b0;
      end
    end
  end

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_inv_factorial.sv
// Scoreboard bench for inv_factorial: directed operands with hand-computed results.
module tb_inv_factorial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in;
  logic [3:0]  out;
  logic        exact;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;
`ifdef INV_FACTORIAL_ABORT_EN
  logic        abort;
`endif

  // Expected record: {out[3:0], exact, latency[3:0], busy_cycles[3:0]}
  logic [12:0] exp_q[$];
  int          st_q[$];

  int cyc;
  int n_vec;
  int n_err;
  int bcnt;

  inv_factorial dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in),
`ifdef INV_FACTORIAL_ABORT_EN
    .abort     (abort),
`endif
    .out       (out),
    .exact     (exact),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [15:0] v, input logic [3:0] eo, input logic ee, input bit push);
    logic [3:0] lat;
    @(posedge clk); #1;
    start = 1'b1;
    in    = v;
    if (push) begin
      lat = (eo == 4'd0) ? 4'd1 : eo + 4'd1;
      exp_q.push_back({eo, ee, lat, lat - 4'd1});
      st_q.push_back(cyc);
    end
    @(posedge clk); #1;
    start = 1'b0;
    in    = ~v;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      st_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [12:0] e;
    logic [12:0] a;
    int          t0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
      end else begin
        if (busy) bcnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: out=%0d exact=%0d with nothing pending (cycle %0d)",
                     out, exact, cyc);
          end else begin
            e  = exp_q.pop_front();
            t0 = st_q.pop_front();
            a  = {out, exact, 4'(cyc - t0), 4'(bcnt)};
            n_vec++;
            if (a !== e) begin
              n_err++;
              $display("FAIL result: out/exact/lat/busy got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                       a[12:9], a[8], a[7:4], a[3:0], e[12:9], e[8], e[7:4], e[3:0]);
            end
          end
          bcnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  n;
    logic        ex;
  } vec_t;

  vec_t vecs[11];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    in    = '0;
`ifdef INV_FACTORIAL_ABORT_EN
    abort = 1'b0;
`endif
    vecs[0]  = '{16'd120,   4'd5, 1'b1};
    vecs[1]  = '{16'd121,   4'd5, 1'b0};
    vecs[2]  = '{16'd1,     4'd1, 1'b1};
    vecs[3]  = '{16'd0,     4'd0, 1'b0};
    vecs[4]  = '{16'd40320, 4'd8, 1'b1};
    vecs[5]  = '{16'd65535, 4'd8, 1'b0};
    vecs[6]  = '{16'd2,     4'd2, 1'b1};
    vecs[7]  = '{16'd3,     4'd2, 1'b0};
    vecs[8]  = '{16'd6,     4'd3, 1'b1};
    vecs[9]  = '{16'd719,   4'd5, 1'b0};
    vecs[10] = '{16'd5040,  4'd7, 1'b1};

    // reset state
    @(negedge clk);
    check("rst_out",   32'(out),       32'd0);
    check("rst_exact", 32'(exact),     32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].v, vecs[i].n, vecs[i].ex, 1'b1);
      wait_idle();
    end

    // start during CALC and during DONE are both ignored
    issue(16'd24, 4'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; in = 16'd720;
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(2);
    check("done_cycle", 32'(done), 32'd1);
    start = 1'b1; in = 16'd720;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    idle_cycles(12);
    check("hold_out",   32'(out),   32'd4);
    check("hold_exact", 32'(exact), 32'd1);

    // reset in the middle of a calculation
    issue(16'd5040, 4'd7, 1'b1, 1'b0);
    idle_cycles(2);
    rst = 1'b1;
    #1;
    check("midrst_out",   32'(out),   32'd0);
    check("midrst_exact", 32'(exact), 32'd0);
    check("midrst_busy",  32'(busy),  32'd0);
    check("midrst_done",  32'(done),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(12);
    issue(16'd6, 4'd3, 1'b1, 1'b1);
    wait_idle();

`ifdef INV_FACTORIAL_ABORT_EN
    // abort mid-CALC returns to IDLE with no done and held results
    issue(16'd720, 4'd6, 1'b1, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_out",   32'(out),       32'd3);
    check("abort_exact", 32'(exact),     32'd1);
    idle_cycles(12);
    abort = 1'b1;
    issue(16'd24, 4'd4, 1'b1, 1'b1);
    abort = 1'b0;
    wait_idle();
`endif

    idle_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_factorial.md
INV_FACTORIAL -- requirements
Module: inv_factorial

Interface
REQ-001 Parameters: none; all widths SHALL come from inv_factorial_pkg constants.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 in  input  16  operand V, unsigned.
REQ-006 out  output  4  result n, the largest n with n! <= V; 0 if V=0.
REQ-007 exact  output  1  1 when n! == V.
REQ-008 busy  output  1  high while in CALC.
REQ-009 done  output  1  one-cycle pulse; out/exact are valid from this cycle.
REQ-010 abort  input  1  present only with INV_FACTORIAL_ABORT_EN.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-012 In IDLE, start=1 SHALL latch in into V, set acc=1 and k=1, and move to CALC. If in==0, it SHALL go directly to DONE with out=0 and exact=0.
REQ-013 Each CALC cycle SHALL compute p = acc*(k+1) at 20-bit width (no truncation).
  - If p<=V: acc<=p, k<=k+1, stay in CALC.
  - Otherwise: out<=k, exact<=(acc==V), go to DONE.
REQ-014 CALC SHALL always terminate by k=8, because 9! = 362880 exceeds any 16-bit V.
REQ-015 Latency for a start accepted in cycle t:
  - done=1 in cycle t+n+1 when n>=1;
  - done=1 in cycle t+1 when V=0;
  - worst case is 9 cycles.
REQ-016 busy SHALL be 1 exactly in CALC cycles. done SHALL be 1 exactly in the DONE cycle. DONE SHALL always return to IDLE.
REQ-017 start SHALL be ignored in CALC and DONE; changes on in after acceptance SHALL have no effect.
REQ-018 out and exact SHALL hold their last result until the next DONE.
REQ-019 V=1 SHALL yield out=1 and exact=1 (the largest n is reported).

Reset
REQ-020 While rst=1, independent of clk:
  - state=IDLE;
  - out=0, exact=0, busy=0, done=0;
  - acc=1, k=1, V=0.
REQ-021 Reset asserted mid-CALC SHALL abandon the operation with no done pulse. The first start after reset release SHALL be served normally.

Configuration
REQ-022 Macro INV_FACTORIAL_ABORT_EN defined: the abort port SHALL exist, and abort=1 in CALC SHALL return to IDLE next cycle with no done pulse and out/exact unchanged. abort SHALL have no effect in IDLE or DONE. If abort and start are both 1 in IDLE, start SHALL win.
REQ-023 Macro undefined: there SHALL be no abort port or logic; behaviour SHALL be per REQ-011..REQ-019.

Structure
REQ-024 inv_factorial_pkg SHALL hold:
  - the state enum (IDLE/CALC/DONE);
  - IN_W=16, N_W=4, ACC_W=20, MAX_N=8.
REQ-025 The 20-bit multiply and compare SHALL be a combinational sub-module fact_step (inputs acc, k, V; outputs p, le). All sequencing SHALL stay in inv_factorial.

Verification
REQ-026 in=120, start in cycle t -> out=5, exact=1, done in t+6, busy high t+1..t+5.
REQ-027 Boundary operands (done cycle relative to start in cycle t):
  - in=121 -> out=5, exact=0;
  - in=1 -> out=1, exact=1, done t+2;
  - in=0 -> out=0, exact=0, done t+1, busy never high.
REQ-028 in=40320 -> out=8, exact=1, done t+9; in=65535 -> out=8, exact=0, done t+9.
REQ-029 start with in=24, then start with in=720 two cycles later -> second start ignored; out=4, exact=1. A start in the DONE cycle is also ignored.
REQ-030 start with in=5040, rst pulsed in t+3 -> outputs 0 immediately and no done. After release, start with in=6 -> out=3, exact=1.
REQ-031 With INV_FACTORIAL_ABORT_EN: start with in=720, abort in t+2 -> IDLE in t+3, no done, out/exact keep prior values.
